// File: rtl/fifo_stream_buffer.sv
// Single-clock FIFO: DEPTH-1 entry array plus a registered first-word-fall-through output stage.
// Optional per-entry even parity is enabled with the FIFO_PARITY_EN macro.
module fifo_stream_buffer #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int DEPTH        = 8,
    parameter  int AF_THRESHOLD = DEPTH - 2,
    parameter  int AE_THRESHOLD = 2,
    localparam int CNT_W        = $clog2(DEPTH + 1),
    localparam int PTR_W        = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1
) (
    input  logic                  clk_in,
    input  logic                  areset,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  rd_parity_err
);

`ifdef FIFO_PARITY_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESHOLD);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESHOLD);

    logic [ENTRY_W-1:0] mem_q [0:DEPTH-2];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic [ENTRY_W-1:0] stage_q, stage_d;
    logic               wr_ready_q, af_q, ae_q, overflow_q;
    logic               wr_acc, rd_acc, stage_open, arr_nonempty, mem_we;
    logic [ENTRY_W-1:0] wr_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 2)) ? '0 : p + 1'b1;
    endfunction

`ifdef FIFO_PARITY_EN
    assign wr_entry = {^wr_data, wr_data};
`else
    assign wr_entry = wr_data;
`endif

    assign wr_acc       = wr_valid && wr_ready_q;
    assign rd_acc       = valid_q && rd_ready;
    assign stage_open   = !valid_q || rd_acc;
    // The array holds whatever the output stage does not.
    assign arr_nonempty = count_q > CNT_W'(valid_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        stage_d  = stage_q;
        mem_we   = 1'b0;
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            valid_d  = 1'b0;
            stage_d  = '0;
            count_d  = '0;
        end else if (stage_open) begin
            if (arr_nonempty) begin
                stage_d  = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
                rd_ptr_d = ptr_inc(rd_ptr_q);
                mem_we   = wr_acc;
            end else if (wr_acc) begin
                stage_d = wr_entry;
                valid_d = 1'b1;
            end else begin
                stage_d = '0;
                valid_d = 1'b0;
            end
        end else begin
            mem_we = wr_acc;
        end
        if (mem_we) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
    end

    always_ff @(posedge clk_in or posedge areset) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            stage_q    <= '0;
            wr_ready_q <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            stage_q    <= stage_d;
            wr_ready_q <= count_d < DEPTH_C;
            af_q       <= count_d >= AF_C;
            ae_q       <= count_d <= AE_C;
            overflow_q <= wr_valid && !wr_ready_q;
        end
    end

    // Storage contents are deliberately not reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign rd_valid     = valid_q;
    assign rd_data      = stage_q[DATA_WIDTH-1:0];
    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = overflow_q;

`ifdef FIFO_PARITY_EN
    assign rd_parity_err = valid_q && (^stage_q);
`else
    assign rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_buffer.sv
// Directed bench for fifo_stream_buffer: a DEPTH=8 instance for handshakes/flags/flush
// and a DEPTH=5 instance for wrap-around ordering.
module tb_fifo_stream_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    int          checks   = 0;
    int          failures = 0;

    // DEPTH=8 instance
    logic        a_flush, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready;
    logic [31:0] a_wr_data, a_rd_data;
    logic [3:0]  a_count;
    logic        a_af, a_ae, a_ovf, a_perr;

    // DEPTH=5 instance
    logic        b_flush, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
    logic [31:0] b_wr_data, b_rd_data;
    logic [2:0]  b_count;
    logic        b_af, b_ae, b_ovf, b_perr;

    fifo_stream_buffer #(.DATA_WIDTH(32), .DEPTH(8)) dut_a (
        .clk_in(clk), .areset(areset), .flush(a_flush),
        .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
        .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
        .count(a_count), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .rd_parity_err(a_perr)
    );

    fifo_stream_buffer #(.DATA_WIDTH(32), .DEPTH(5)) dut_b (
        .clk_in(clk), .areset(areset), .flush(b_flush),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .rd_parity_err(b_perr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          sent, got, bcnt, cyc;
        logic        wa, ra;
        logic [7:0]  rd_pat;

        areset = 1'b1;
        a_flush = 0; a_wr_valid = 0; a_rd_ready = 0; a_wr_data = '0;
        b_flush = 0; b_wr_valid = 0; b_rd_ready = 0; b_wr_data = '0;
        tick(); tick();

        // Reset state
        check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        check("rst_rd_data",  a_rd_data,       32'd0);
        check("rst_count",    32'(a_count),    32'd0);
        check("rst_wr_ready", 32'(a_wr_ready), 32'd0);
        check("rst_ae",       32'(a_ae),       32'd1);
        check("rst_af",       32'(a_af),       32'd0);
        check("rst_ovf",      32'(a_ovf),      32'd0);
        check("rst_perr",     32'(a_perr),     32'd0);

        areset = 1'b0;
        tick();
        check("wr_ready_up", 32'(a_wr_ready), 32'd1);

        // Single write falls through after one edge
        a_wr_valid = 1; a_wr_data = 32'hA5A5_0001;
        tick();
        a_wr_valid = 0;
        check("single_valid", 32'(a_rd_valid), 32'd1);
        check("single_data",  a_rd_data,       32'hA5A5_0001);
        check("single_count", 32'(a_count),    32'd1);
        check("single_ae",    32'(a_ae),       32'd1);
        tick();
        check("hold_data",    a_rd_data,       32'hA5A5_0001);
        a_rd_ready = 1;
        tick();
        a_rd_ready = 0;
        check("drain1_valid", 32'(a_rd_valid), 32'd0);
        check("drain1_data",  a_rd_data,       32'd0);
        check("drain1_count", 32'(a_count),    32'd0);

        // Fill to DEPTH with reads stalled
        for (int i = 0; i < 8; i++) begin
            a_wr_valid = 1; a_wr_data = 32'(i);
            tick();
            check("fill_count", 32'(a_count), 32'(i + 1));
            check("fill_af",    32'(a_af),    32'((i + 1) >= 6));
            check("fill_ae",    32'(a_ae),    32'((i + 1) <= 2));
        end
        check("full_wr_ready", 32'(a_wr_ready), 32'd0);
        check("full_head",     a_rd_data,       32'd0);

        // Ninth write is rejected and pulses overflow once
        a_wr_data = 32'd99;
        tick();
        a_wr_valid = 0;
        check("ovf_pulse", 32'(a_ovf),   32'd1);
        check("ovf_count", 32'(a_count), 32'd8);
        tick();
        check("ovf_clear", 32'(a_ovf),   32'd0);

        // Full: simultaneous read and write -> only the read is taken
        a_wr_valid = 1; a_wr_data = 32'd8; a_rd_ready = 1;
        tick();
        a_rd_ready = 0;
        check("fr_count",    32'(a_count),    32'd7);
        check("fr_data",     a_rd_data,       32'd1);
        check("fr_wr_ready", 32'(a_wr_ready), 32'd1);
        tick();
        a_wr_valid = 0;
        check("fr_refill",   32'(a_count),    32'd8);

        // Drain 1..8 in order
        a_rd_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", a_rd_data, 32'(i));
            tick();
        end
        a_rd_ready = 0;
        check("drained_valid", 32'(a_rd_valid), 32'd0);
        check("drained_count", 32'(a_count),    32'd0);

        // Flush with 4 entries held overrides both handshakes
        for (int i = 0; i < 4; i++) begin
            a_wr_valid = 1; a_wr_data = 32'(10 + i);
            tick();
        end
        check("pre_flush_count", 32'(a_count), 32'd4);
        a_flush = 1; a_wr_data = 32'd55; a_rd_ready = 1;
        tick();
        a_flush = 0; a_rd_ready = 0;
        check("flush_count", 32'(a_count),    32'd0);
        check("flush_valid", 32'(a_rd_valid), 32'd0);
        check("flush_data",  a_rd_data,       32'd0);
        check("flush_ae",    32'(a_ae),       32'd1);
        a_wr_data = 32'd77;
        tick();
        a_wr_valid = 0;
        check("post_flush_data",  a_rd_data,    32'd77);
        check("post_flush_count", 32'(a_count), 32'd1);

        // Streaming: one write and one read per cycle, no bubbles
        a_rd_ready = 1; a_wr_valid = 1;
        for (int k = 0; k < 5; k++) begin
            a_wr_data = 32'(200 + k);
            tick();
            check("stream_data",  a_rd_data,    32'(200 + k));
            check("stream_count", 32'(a_count), 32'd1);
        end
        a_wr_valid = 0;
        tick();
        a_rd_ready = 0;
        check("stream_end", 32'(a_rd_valid), 32'd0);
        check("parity_off", 32'(a_perr),     32'd0);

        // DEPTH=5: 20 items through a 4-entry array with a stalling consumer
        sent = 0; got = 0; bcnt = 0; cyc = 0;
        rd_pat = 8'b1001_0001;
        while (got < 20 && cyc < 400) begin
            b_wr_valid = (sent < 20);
            b_wr_data  = 32'(1000 + sent);
            b_rd_ready = rd_pat[cyc % 8];
            wa = b_wr_valid && b_wr_ready;
            ra = b_rd_valid && b_rd_ready;
            if (ra) begin
                check("b_order", b_rd_data, 32'(1000 + got));
                got++;
            end
            if (wa) sent++;
            bcnt = bcnt + int'(wa) - int'(ra);
            tick();
            check("b_count", 32'(b_count), 32'(bcnt));
            cyc++;
        end
        b_wr_valid = 0; b_rd_ready = 0;
        check("b_all_received", 32'(got), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
